traceback_decoder: RTL and testbench

TRACEBACK_DECODER -- requirements
Module: traceback_decoder

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/tb_col_mem.sv | 31 +++
 rtl/traceback_decoder.sv | 112 +++++++++++
 tb/tb_traceback_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions for the ACS, path-memory and traceback blocks.
// Holds the default block depth, the 2-bit state encodings and the traceback FSM states.
// No logic of its own.
package viterbi_pkg;

   localparam int TB_DEPTH = 8;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S01 = 2'b01;
   localparam logic [1:0] S10 = 2'b10;
   localparam logic [1:0] S11 = 2'b11;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_TRACE = 2'd1,
      ST_EMIT  = 2'd2
   } tb_fsm_e;

endpackage

// File: rtl/tb_col_mem.sv
// Survivor column store: DEPTH x 4-bit register file, one write port, one async read port.
// Write lands on the clock edge; read is combinational from the registered array.
// No backpressure; the caller decides when to write.
module tb_col_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [3:0]    rdata
);

   logic [3:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 4'b0000;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/traceback_decoder.sv
// Block traceback for a K=3 rate-1/2 Viterbi decoder: fill TB_DEPTH columns, trace back, emit bits.
// First decoded bit appears TB_DEPTH+1 cycles after the last column handshake.
// sel_ready is low during TRACE/EMIT; dec_bit/dec_valid hold while dec_ready is low.
module traceback_decoder #(
   parameter int TB_DEPTH = viterbi_pkg::TB_DEPTH,
   parameter int CNT_W    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] acs_sel,
   input  logic       sel_valid,
   output logic       sel_ready,
   input  logic [1:0] best_state,
   output logic       dec_bit,
   output logic       dec_valid,
   input  logic       dec_ready,
   output logic       busy
);

   import viterbi_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TB_DEPTH - 1);

   tb_fsm_e              state, state_nxt;
   logic                 ready_en;
   logic [CNT_W-1:0]     wr_idx;
   logic [CNT_W-1:0]     rd_idx;
   logic [CNT_W-1:0]     tr_idx;
   logic [1:0]           tr_state;
   logic [TB_DEPTH-1:0]  out_buf;
   logic [3:0]           col_rd;
   logic                 col_we;

   assign sel_ready = (state == ST_FILL) && ready_en;
   assign col_we    = sel_ready && sel_valid;
   assign dec_valid = (state == ST_EMIT);
   assign dec_bit   = (state == ST_EMIT) ? out_buf[rd_idx] : 1'b0;
   assign busy      = (state == ST_TRACE) || (state == ST_EMIT);

   tb_col_mem #(
      .DEPTH (TB_DEPTH),
      .AW    (CNT_W)
   ) u_col_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (col_we),
      .waddr (wr_idx),
      .wdata (acs_sel),
      .raddr (tr_idx),
      .rdata (col_rd)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_FILL:  if (col_we && (wr_idx == LAST)) state_nxt = ST_TRACE;
         ST_TRACE: if (tr_idx == '0) state_nxt = ST_EMIT;
         ST_EMIT:  if (dec_ready && (rd_idx == LAST)) state_nxt = ST_FILL;
         default:  state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // ready_en keeps sel_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         wr_idx   <= '0;
         rd_idx   <= '0;
         tr_idx   <= LAST;
         tr_state <= S00;
         out_buf  <= '0;
      end else begin
         ready_en <= 1'b1;
         unique case (state)
            ST_FILL: begin
               if (col_we) begin
                  if (wr_idx == LAST) begin
                     wr_idx   <= '0;
                     tr_idx   <= LAST;
                     tr_state <= best_state;
                  end else begin
                     wr_idx <= wr_idx + CNT_W'(1);
                  end
               end
            end
            ST_TRACE: begin
               // Decoded bit is the state's MSB; predecessor shifts in the survivor decision
               out_buf[tr_idx] <= tr_state[1];
               tr_state        <= {tr_state[0], col_rd[tr_state]};
               tr_idx          <= (tr_idx == '0) ? LAST : tr_idx - CNT_W'(1);
            end
            ST_EMIT: begin
               if (dec_ready) begin
                  rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + CNT_W'(1);
               end
            end
            default: begin
               wr_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_traceback_decoder.sv
// Scenario bench for traceback_decoder: expected bits queued at fill time, popped on each output handshake.
module tb_traceback_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] acs_sel = 4'h0;
   logic       sel_valid = 1'b0;
   logic       sel_ready;
   logic [1:0] best_state = 2'b00;
   logic       dec_bit;
   logic       dec_valid;
   logic       dec_ready = 1'b0;
   logic       busy;

   int checks = 0;
   int failures = 0;
   bit exp_q[$];

   localparam logic [7:0][3:0] COLS_ZERO = '0;
   localparam logic [7:0][3:0] COLS_PATH = {4'b0000, 4'b0000, 4'b0001, 4'b0010,
                                            4'b0000, 4'b0100, 4'b0000, 4'b0000};
   localparam logic [7:0] EXP_ZERO = 8'b0000_0000;
   localparam logic [7:0] EXP_PATH = 8'b0100_1101;

   traceback_decoder #(.TB_DEPTH(8), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .acs_sel    (acs_sel),
      .sel_valid  (sel_valid),
      .sel_ready  (sel_ready),
      .best_state (best_state),
      .dec_bit    (dec_bit),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic fill_block(input logic [7:0][3:0] cols, input logic [1:0] best,
                             input logic [7:0] exp_bits, input bit gaps, input bit junk);
      int guard;
      for (int i = 0; i < 8; i++) exp_q.push_back(exp_bits[i]);
      for (int i = 0; i < 8; i++) begin
         if (gaps && (i % 3 == 1)) begin
            sel_valid = 1'b0; acs_sel = 4'hF; best_state = ~best;
            @(posedge clk); @(negedge clk);
         end
         sel_valid = 1'b1; acs_sel = cols[i];
         best_state = (i == 7) ? best : ~best;
         guard = 0;
         while (!sel_ready && guard < 40) begin
            @(posedge clk); @(negedge clk); guard++;
         end
         checks++;
         if (sel_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_ready col=%0d sel_ready=%b expected 1", i, sel_ready);
         end
         @(posedge clk); @(negedge clk);
      end
      sel_valid = junk;
      acs_sel = junk ? 4'hF : 4'h0;
      best_state = 2'b11;
   endtask

   task automatic collect(input string tag, input bit chk_lat, input int bp_bit);
      int waitc;
      int guard;
      bit exp;
      waitc = 1;
      while (!dec_valid && waitc < 60) begin
         checks++;
         if (sel_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s trace_flags sel_ready=%b busy=%b expected 0/1", tag, sel_ready, busy);
         end
         @(posedge clk); waitc++; @(negedge clk);
      end
      sel_valid = 1'b0; acs_sel = 4'h0;
      checks++;
      if (dec_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s first_valid_timeout dec_valid=%b expected 1", tag, dec_valid);
         return;
      end
      if (chk_lat) begin
         checks++;
         if (waitc != 9) begin
            failures++;
            $display("FAIL %s latency got=%0d expected 9", tag, waitc);
         end
      end
      for (int b = 0; b < 8; b++) begin
         guard = 0;
         while (!dec_valid && guard < 20) begin
            @(posedge clk); @(negedge clk); guard++;
         end
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard_empty bit=%0d", tag, b);
            return;
         end
         exp = exp_q.pop_front();
         checks++;
         if (dec_valid !== 1'b1 || dec_bit !== exp) begin
            failures++;
            $display("FAIL %s bit%0d dec_valid=%b dec_bit=%b expected 1/%b", tag, b, dec_valid, dec_bit, exp);
         end
         checks++;
         if (sel_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s emit_sel_ready bit%0d got=%b expected 0", tag, b, sel_ready);
         end
         if (b == bp_bit) begin
            dec_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); @(negedge clk);
               checks++;
               if (dec_valid !== 1'b1 || dec_bit !== exp || sel_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL %s backpressure v=%b bit=%b rdy=%b expected 1/%b/0",
                           tag, dec_valid, dec_bit, sel_ready, exp);
               end
            end
         end
         dec_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         dec_ready = 1'b0;
      end
      checks++;
      if (sel_ready !== 1'b1 || dec_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s block_end rdy=%b v=%b busy=%b expected 1/0/0", tag, sel_ready, dec_valid, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (sel_ready !== 1'b0 || dec_valid !== 1'b0 || dec_bit !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs rdy=%b v=%b bit=%b busy=%b expected 0/0/0/0",
                  sel_ready, dec_valid, dec_bit, busy);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (sel_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_early sel_ready=%b expected 0", sel_ready);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (sel_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_edge sel_ready=%b busy=%b expected 1/0", sel_ready, busy);
      end
   endtask

   task automatic test_all_zero();
      fill_block(COLS_ZERO, 2'b00, EXP_ZERO, 1'b0, 1'b0);
      collect("all_zero", 1'b1, -1);
   endtask

   task automatic test_known_path();
      fill_block(COLS_PATH, 2'b01, EXP_PATH, 1'b0, 1'b0);
      collect("known_path", 1'b1, -1);
   endtask

   task automatic test_backpressure();
      fill_block(COLS_PATH, 2'b01, EXP_PATH, 1'b0, 1'b0);
      collect("backpressure", 1'b0, 3);
   endtask

   task automatic test_stall_ignore();
      fill_block(COLS_PATH, 2'b01, EXP_PATH, 1'b1, 1'b1);
      collect("stall_ignore", 1'b0, -1);
   endtask

   task automatic test_reset_mid_trace();
      fill_block(COLS_PATH, 2'b01, EXP_PATH, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dec_valid !== 1'b0 || busy !== 1'b0 || sel_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_low v=%b busy=%b rdy=%b expected 0/0/0", dec_valid, busy, sel_ready);
      end
      exp_q.delete();
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (dec_valid !== 1'b0 || busy !== 1'b0 || sel_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_release v=%b busy=%b rdy=%b expected 0/0/1", dec_valid, busy, sel_ready);
      end
      repeat (12) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (dec_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle dec_valid=%b expected 0", dec_valid);
         end
      end
      fill_block(COLS_ZERO, 2'b00, EXP_ZERO, 1'b0, 1'b0);
      collect("midreset_zero", 1'b1, -1);
   endtask

   task automatic test_back_to_back();
      fill_block(COLS_PATH, 2'b01, EXP_PATH, 1'b0, 1'b0);
      collect("b2b_blk1", 1'b1, -1);
      fill_block(COLS_ZERO, 2'b00, EXP_ZERO, 1'b0, 1'b0);
      collect("b2b_blk2", 1'b1, -1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_leftover size=%0d expected 0", exp_q.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_all_zero();
      test_known_path();
      test_backpressure();
      test_stall_ignore();
      test_reset_mid_trace();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
